// File: rtl/wt_cpa_pipe.sv
// ---------------------------------------------------------------------------
// wt_cpa_pipe -- final carry-propagate adder of the 8x16 Wallace multiplier.
//
// Resolves the redundant sum/carry pair from the last compressor row into
// the binary product. The add is split at bit SPLIT so that each stage only
// ripples across half the word:
//   stage 1 : low SPLIT bits added, carry into bit SPLIT registered,
//             high halves of sum/carry passed through unchanged
//   stage 2 : high halves added together with the stage-1 carry
// Both stages use valid/ready handshakes and sustain one result per cycle.
//
// Parameters
//   W      width of sum/carry vectors and of the product (default 24)
//   SPLIT  split bit position, legal range 1..W-1 (default 12)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream vector pair valid
//   in_ready   pipeline can accept a pair this cycle
//   in_sum     sum vector, weight-aligned
//   in_carry   carry vector, aligned to in_sum
//   out_valid  product valid
//   out_ready  downstream accepts the product
//   out_prod   (in_sum + in_carry) mod 2^W
//   out_cout   carry out of bit W-1
//   out_count  (only with WT_CPA_CNT_EN) saturating count of delivered
//              products
//
// Optional feature macro: WT_CPA_CNT_EN
// ---------------------------------------------------------------------------
module wt_cpa_pipe #(
  parameter int W     = 24,
  parameter int SPLIT = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_sum,
  input  logic [W-1:0] in_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
`ifdef WT_CPA_CNT_EN
  output logic         out_cout,
  output logic [15:0]  out_count
`else
  output logic         out_cout
`endif
);

  localparam int HW = W - SPLIT;

  // stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0]  s1_lo_q,    s1_lo_d;
  logic              s1_c_q,     s1_c_d;
  logic [HW-1:0]     s1_hs_q,    s1_hs_d;
  logic [HW-1:0]     s1_hc_q,    s1_hc_d;

  // stage 2 state (drives the outputs directly)
  logic              s2_valid_q, s2_valid_d;
  logic [W-1:0]      prod_q,     prod_d;
  logic              cout_q,     cout_d;

  logic              s2_ready;
  logic              acc, xfer, drain;
  logic [SPLIT:0]    lo_add;
  logic [HW:0]       hi_add;

  // Ready only looks at registered valids, so there is no path from
  // in_valid to out_valid.
  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  assign acc   = in_valid   && in_ready;
  assign xfer  = s1_valid_q && s2_ready;
  assign drain = s2_valid_q && out_ready;

  assign lo_add = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
  assign hi_add = {1'b0, s1_hs_q} + {1'b0, s1_hc_q} + {{HW{1'b0}}, s1_c_q};

  always_comb begin
    // valids: a fill wins over a drain, so drain+fill keeps the stage full
    s1_valid_d = acc  ? 1'b1 : (xfer  ? 1'b0 : s1_valid_q);
    s2_valid_d = xfer ? 1'b1 : (drain ? 1'b0 : s2_valid_q);

    // data registers load only on transfer into their stage
    s1_lo_d = s1_lo_q;
    s1_c_d  = s1_c_q;
    s1_hs_d = s1_hs_q;
    s1_hc_d = s1_hc_q;
    if (acc) begin
      s1_lo_d = lo_add[SPLIT-1:0];
      s1_c_d  = lo_add[SPLIT];
      s1_hs_d = in_sum[W-1:SPLIT];
      s1_hc_d = in_carry[W-1:SPLIT];
    end

    prod_d = prod_q;
    cout_d = cout_q;
    if (xfer) begin
      prod_d = {hi_add[HW-1:0], s1_lo_q};
      cout_d = hi_add[HW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_hs_q    <= '0;
      s1_hc_q    <= '0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      cout_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c_q     <= s1_c_d;
      s1_hs_q    <= s1_hs_d;
      s1_hc_q    <= s1_hc_d;
      s2_valid_q <= s2_valid_d;
      prod_q     <= prod_d;
      cout_q     <= cout_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_prod  = prod_q;
  assign out_cout  = cout_q;

`ifdef WT_CPA_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // saturates so a long run never wraps back to a small value
  always_comb begin
    cnt_d = cnt_q;
    if (drain && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_wt_cpa_pipe.sv
module tb_wt_cpa_pipe;

  localparam int W = 24;
  typedef logic [W:0] res_t;   // {cout, prod}

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic         out_cout;
`ifdef WT_CPA_CNT_EN
  logic [15:0]  out_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  res_t exp_q[$];
  res_t obs_q[$];
  int   acc_cyc_q[$];
  int   fire_cyc_q[$];

  wt_cpa_pipe #(.W(W), .SPLIT(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
`ifdef WT_CPA_CNT_EN
    .out_cout  (out_cout),
    .out_count (out_count)
`else
    .out_cout  (out_cout)
`endif
  );

  always #5 clk = ~clk;

  // One cycle: sample handshakes mid-cycle, push expected result on accept
  // and observed result on delivery, then advance to the next negedge.
  task automatic tick(output bit acc);
    #1;
    acc = rst_n && in_valid && in_ready;
    if (acc) begin
      exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
      acc_cyc_q.push_back(cyc);
    end
    if (rst_n && out_valid && out_ready) begin
      obs_q.push_back({out_cout, out_prod});
      fire_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(output bit timeout);
    bit a;
    int n;
    timeout = 0;
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 50) begin
      tick(a);
      n++;
    end
    if (obs_q.size() < exp_q.size()) timeout = 1;
    repeat (3) tick(a);   // any duplicate would show up as an extra entry
  endtask

  function automatic void rand_pair(output logic [W-1:0] s, output logic [W-1:0] c);
    logic [7:0]  a;
    logic [15:0] b;
    logic [W-1:0] p;
    a = 8'($urandom);
    b = 16'($urandom);
    p = W'(a) * W'(b);
    c = W'($urandom);
    s = p - c;
  endfunction

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; in_sum = '0; in_carry = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_prod !== '0) begin bad++; $display("FAIL reset_out_prod: got %h want 000000", out_prod); end
    total++; if (out_cout !== 1'b0) begin bad++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
    rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_corners();
    logic [W-1:0] s_tab [3] = '{24'h000FFF, 24'hFFFFFF, 24'h800000};
    logic [W-1:0] c_tab [3] = '{24'h000001, 24'h000001, 24'h800000};
    res_t want_tab [3] = '{25'h0001000, 25'h1000000, 25'h1000000};
    res_t o;
    bit a, to;
    acc_cyc_q.delete(); fire_cyc_q.delete();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_sum = s_tab[i]; in_carry = c_tab[i];
      tick(a);
      in_valid = 0;
      repeat (3) tick(a);
    end
    drain(to);
    total++; if (to) begin bad++; $display("FAIL corner_timeout: got %0d results want %0d", obs_q.size(), exp_q.size()); end
    total++;
    if (fire_cyc_q.size() < 1 || acc_cyc_q.size() < 1 || fire_cyc_q[0] - acc_cyc_q[0] != 2) begin
      bad++; $display("FAIL corner_latency: got %0d want 2",
                      (fire_cyc_q.size() > 0 && acc_cyc_q.size() > 0) ? fire_cyc_q[0] - acc_cyc_q[0] : -1);
    end
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL corner_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      total++;
      if (o !== want_tab[i]) begin bad++; $display("FAIL corner[%0d]: got %h want %h", i, o, want_tab[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, c;
    res_t e, o;
    bit a, to;
    acc_cyc_q.delete(); fire_cyc_q.delete();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin c = W'($urandom); s = 24'hFEFF01 - c; end   // FF*FFFF
      else rand_pair(s, c);
      in_valid = 1; in_sum = s; in_carry = c;
      tick(a);
    end
    drain(to);
    total++; if (to) begin bad++; $display("FAIL stream_timeout: got %0d results want %0d", obs_q.size(), exp_q.size()); end
    total++; if (acc_cyc_q.size() != 8 || fire_cyc_q.size() != 8) begin
      bad++; $display("FAIL stream_count: got acc=%0d out=%0d want 8/8", acc_cyc_q.size(), fire_cyc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (fire_cyc_q[i] != acc_cyc_q[0] + 2 + i) begin
          bad++; $display("FAIL stream_timing[%0d]: got cycle %0d want %0d", i, fire_cyc_q[i], acc_cyc_q[0] + 2 + i);
        end
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL stream_data: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s_tab [3];
    logic [W-1:0] c_tab [3];
    res_t first, e, o;
    bit a, to;
    int idx, n;
    for (int i = 0; i < 3; i++) rand_pair(s_tab[i], c_tab[i]);
    first = {1'b0, s_tab[0]} + {1'b0, c_tab[0]};
    out_ready = 0;
    idx = 0;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1; in_sum = s_tab[idx]; in_carry = c_tab[idx];
      #1;
      if (t >= 2) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", t, in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", t, out_valid); end
        total++; if ({out_cout, out_prod} !== first) begin
          bad++; $display("FAIL bp_hold[%0d]: got %h want %h", t, {out_cout, out_prod}, first);
        end
      end
      tick(a);
      if (a) idx++;
    end
    total++; if (idx != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    out_ready = 1;
    n = 0;
    while (idx < 3 && n < 20) begin
      in_valid = 1; in_sum = s_tab[idx]; in_carry = c_tab[idx];
      tick(a);
      if (a) idx++;
      n++;
    end
    drain(to);
    total++; if (to || idx != 3) begin bad++; $display("FAIL bp_timeout: got accepted=%0d want 3", idx); end
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL bp_data: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] s, c;
    res_t e, o;
    bit a, to;
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      rand_pair(s, c);
      in_valid = 1; in_sum = s; in_carry = c;
      tick(a);
    end
    in_valid = 0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill: got %b want 1", out_valid); end
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    repeat (4) tick(a);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_stale: got %0d results want 0", obs_q.size()); end
    in_valid = 1; in_sum = 24'h123456; in_carry = 24'h0EDCBA;
    tick(a);
    drain(to);
    total++; if (to || obs_q.size() != 1) begin bad++; $display("FAIL mid_after: got %0d results want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL mid_data: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef WT_CPA_CNT_EN
  task automatic test_count();
    logic [W-1:0] s, c;
    bit a, to;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      rand_pair(s, c);
      in_valid = 1; in_sum = s; in_carry = c;
      tick(a);
    end
    drain(to);
    total++; if (out_count !== 16'd5) begin bad++; $display("FAIL count_5: got %0d want 5", out_count); end
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    for (int i = 0; i < 3; i++) begin
      rand_pair(s, c);
      in_valid = 1; in_sum = s; in_carry = c;
      tick(a);
    end
    drain(to);
    total++; if (out_count !== 16'hFFFF) begin bad++; $display("FAIL count_sat: got %h want ffff", out_count); end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef WT_CPA_CNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
